// File: rtl/pc_push_sequencer.sv
// Pushes a CALL/INT return frame (PC low, PC high, optional flags) to data memory,
// decrementing SP once per acknowledged word and stalling the front end meanwhile.
module pc_push_sequencer #(
    parameter int                ADDR_W  = 16,
    parameter logic [ADDR_W-1:0] SP_INIT = {ADDR_W{1'b1}}
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              call_req,
    input  logic              int_req,
    input  logic [31:0]       ret_pc,
    input  logic [3:0]        flags_in,
    input  logic [ADDR_W-1:0] sp_in,
    input  logic              mem_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic              sp_wr_en,
    output logic [ADDR_W-1:0] sp_wr_data,
    output logic              stall,
    output logic              push_done,
    output logic              sp_wrap
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PUSH_LO = 3'd1,
        PUSH_HI = 3'd2,
        PUSH_FL = 3'd3,
        DONE    = 3'd4
    } state_t;

    typedef struct packed {
        logic        is_int;
        logic [31:0] pc;
        logic [3:0]  flags;
    } frame_t;

    state_t            state, state_nxt;
    frame_t            frame;
    logic [ADDR_W-1:0] sp;
    logic [ADDR_W-1:0] sp_dec;
    logic              accept;
    logic              ack;

    assign sp_dec = sp - {{(ADDR_W-1){1'b0}}, 1'b1};
    assign accept = (state == IDLE) && (call_req || int_req);
    assign ack    = mem_we && mem_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            frame   <= '0;
            sp      <= '0;
            sp_wrap <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                // int_req wins a tie; flags only matter for the INT frame
                frame.is_int <= int_req;
                frame.pc     <= ret_pc;
                frame.flags  <= int_req ? flags_in : 4'h0;
                sp           <= sp_in;
            end else if (ack) begin
                sp <= sp_dec;
                if (sp == '0)
                    sp_wrap <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = 16'h0000;
        sp_wr_en   = 1'b0;
        sp_wr_data = '0;
        stall      = 1'b1;
        push_done  = 1'b0;

        case (state)
            IDLE: begin
                // Stall already in the request cycle so the front end freezes on accept
                stall = (call_req || int_req) && !reset;
                if (accept)
                    state_nxt = PUSH_LO;
            end
            PUSH_LO: begin
                mem_we    = 1'b1;
                mem_addr  = sp;
                mem_wdata = frame.pc[15:0];
                if (mem_ready)
                    state_nxt = PUSH_HI;
            end
            PUSH_HI: begin
                mem_we    = 1'b1;
                mem_addr  = sp;
                mem_wdata = frame.pc[31:16];
                if (mem_ready)
                    state_nxt = frame.is_int ? PUSH_FL : DONE;
            end
            PUSH_FL: begin
                mem_we    = 1'b1;
                mem_addr  = sp;
                mem_wdata = {12'h000, frame.flags};
                if (mem_ready)
                    state_nxt = DONE;
            end
            DONE: begin
                push_done = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                stall     = 1'b0;
                state_nxt = IDLE;
            end
        endcase

        if (ack) begin
            sp_wr_en   = 1'b1;
            sp_wr_data = sp_dec;
        end
    end

endmodule

// File: tb/tb_pc_push_sequencer.sv
// Bench for pc_push_sequencer: a scoreboard of expected memory writes / SP commits,
// a table of frames, and hand sequences for backpressure, priority, wrap and reset.
module tb_pc_push_sequencer;

    localparam int ADDR_W = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              call_req, int_req;
    logic [31:0]       ret_pc;
    logic [3:0]        flags_in;
    logic [ADDR_W-1:0] sp_in;
    logic              mem_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic              sp_wr_en;
    logic [ADDR_W-1:0] sp_wr_data;
    logic              stall, push_done, sp_wrap;

    pc_push_sequencer #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .call_req(call_req), .int_req(int_req),
        .ret_pc(ret_pc), .flags_in(flags_in), .sp_in(sp_in), .mem_ready(mem_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .sp_wr_en(sp_wr_en), .sp_wr_data(sp_wr_data), .stall(stall),
        .push_done(push_done), .sp_wrap(sp_wrap)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
        logic [15:0] spn;
    } wr_t;

    typedef struct {
        bit          is_int;
        logic [15:0] sp;
        logic [31:0] pc;
        logic [3:0]  fl;
        int          lat;
    } vec_t;

    wr_t exp_q[$];
    int  tests = 0;
    int  fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Scoreboard: every acknowledged write must match the next expected word and SP commit
    always @(negedge clk) begin
        if (!reset) begin
            if (mem_we && mem_ready) begin
                wr_t e;
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_write: addr %h data %h", mem_addr, mem_wdata);
                end else begin
                    e = exp_q.pop_front();
                    if (mem_addr !== e.addr || mem_wdata !== e.data ||
                        sp_wr_en !== 1'b1 || sp_wr_data !== e.spn) begin
                        fails++;
                        $display("FAIL write: got %h@%h spwe=%b spd=%h expected %h@%h spd=%h",
                                 mem_wdata, mem_addr, sp_wr_en, sp_wr_data, e.data, e.addr, e.spn);
                    end
                end
            end else if (sp_wr_en) begin
                tests++;
                fails++;
                $display("FAIL sp_wr_en_without_ack: got 1 expected 0");
            end
        end
    end

    task automatic expect_frame(input bit is_int, input logic [15:0] sp,
                                input logic [31:0] pc, input logic [3:0] fl);
        logic [15:0] a;
        a = sp;
        exp_q.push_back('{addr: a, data: pc[15:0],  spn: a - 16'd1}); a = a - 16'd1;
        exp_q.push_back('{addr: a, data: pc[31:16], spn: a - 16'd1}); a = a - 16'd1;
        if (is_int)
            exp_q.push_back('{addr: a, data: {12'h000, fl}, spn: a - 16'd1});
    endtask

    // Drives one frame, holds the request until push_done, checks latency.
    // hold = number of cycles mem_ready is low starting at the PUSH_HI cycle.
    task automatic run_frame(input string name, input bit is_int, input bit both,
                             input logic [15:0] sp, input logic [31:0] pc,
                             input logic [3:0] fl, input int hold, input int lat);
        int cyc;
        bit seen;
        expect_frame(is_int, sp, pc, fl);
        @(posedge clk); #1;
        int_req   = is_int;
        call_req  = !is_int || both;
        sp_in     = sp;
        ret_pc    = pc;
        flags_in  = fl;
        mem_ready = 1'b1;
        #1 check({name, "_stall_req"}, {31'd0, stall}, 32'd1);
        seen = 1'b0;
        for (cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (push_done) begin
                seen = 1'b1;
                break;
            end
            if (hold > 0 && !mem_ready)
                check({name, "_held_word"}, {mem_we, sp_wr_en, mem_addr, mem_wdata[13:0]},
                      {1'b1, 1'b0, sp - 16'd1, pc[29:16]});
            @(posedge clk); #1;
            // Scrambling the inputs after accept must not disturb the frame
            ret_pc   = $urandom;
            flags_in = 4'($urandom);
            sp_in    = 16'($urandom);
            mem_ready = !((cyc + 1) >= 2 && (cyc + 1) < 2 + hold);
        end
        check({name, "_done_seen"}, {31'd0, seen}, 32'd1);
        check({name, "_latency"}, cyc, lat);
        check({name, "_stall_done"}, {31'd0, stall}, 32'd1);
        call_req = 1'b0;
        int_req  = 1'b0;
        @(posedge clk); #1;
        check({name, "_idle_outs"}, {stall, push_done, mem_we}, 3'b000);
        check({name, "_queue_empty"}, exp_q.size(), 0);
    endtask

    vec_t vecs[4];

    initial begin
        reset = 1'b1; call_req = 0; int_req = 0; ret_pc = 0; flags_in = 0;
        sp_in = 0; mem_ready = 1'b1;
        #12;
        check("reset_outs", {mem_we, sp_wr_en, stall, push_done, sp_wrap},  5'b0);
        check("reset_busses", {mem_addr, mem_wdata}, 32'd0);
        @(posedge clk); #1 reset = 1'b0;

        vecs[0] = '{is_int: 0, sp: 16'h0FFF, pc: 32'h0001_0025, fl: 4'h0, lat: 3};
        vecs[1] = '{is_int: 1, sp: 16'h0800, pc: 32'h0000_0040, fl: 4'b1010, lat: 4};
        vecs[2] = '{is_int: 1, sp: 16'h0003, pc: 32'hDEAD_BEEF, fl: 4'hF, lat: 4};
        vecs[3] = '{is_int: 0, sp: 16'h1234, pc: 32'hFFFF_0000, fl: 4'h5, lat: 3};
        for (int i = 0; i < 4; i++)
            run_frame($sformatf("vec%0d", i), vecs[i].is_int, 1'b0, vecs[i].sp,
                      vecs[i].pc, vecs[i].fl, 0, vecs[i].lat);
        check("no_wrap_yet", {31'd0, sp_wrap}, 32'd0);

        run_frame("backpressure", 1'b0, 1'b0, 16'h0400, 32'h00AB_00CD, 4'h0, 3, 6);
        run_frame("both_reqs", 1'b1, 1'b1, 16'h0200, 32'h1111_2222, 4'h6, 0, 4);
        repeat (3) @(posedge clk);
        #1 check("no_second_frame", {31'd0, mem_we}, 32'd0);

        run_frame("wrap", 1'b0, 1'b0, 16'h0000, 32'h0007_0008, 4'h0, 0, 3);
        check("wrap_set", {31'd0, sp_wrap}, 32'd1);
        run_frame("wrap_sticky", 1'b0, 1'b0, 16'h0050, 32'h0000_0001, 4'h0, 0, 3);
        check("wrap_still_set", {31'd0, sp_wrap}, 32'd1);

        // Reset once the first word of a CALL is acked
        expect_frame(1'b0, 16'h0900, 32'h0033_0044, 4'h0);
        @(posedge clk); #1;
        call_req = 1'b1; sp_in = 16'h0900; ret_pc = 32'h0033_0044; mem_ready = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        check("mid_reset_one_word_left", exp_q.size(), 1);
        reset = 1'b1; call_req = 1'b0;
        #1;
        check("mid_reset_outs", {mem_we, stall, push_done, sp_wr_en}, 4'b0000);
        check("mid_reset_wrap_clr", {31'd0, sp_wrap}, 32'd0);
        void'(exp_q.pop_front());
        @(posedge clk); #1 reset = 1'b0;
        run_frame("after_reset", 1'b0, 1'b0, 16'h0100, 32'hCAFE_F00D, 4'h0, 0, 3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
